// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width, byte type and FIFO pointer-width helper.
// Used by both the RX and TX buffers.
package uart_pkg;

    localparam int unsigned UART_DATA_W = 8;

    typedef logic [UART_DATA_W-1:0] uart_byte_t;

    // Pointer width for a power-of-two FIFO of the given depth.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Receiver-side and host-side signal bundle of the UART RX FIFO.
// The slave modport is the FIFO; the master modport is the receiver/host side.
interface uart_rx_fifo_if #(
    parameter int unsigned DEPTH = 16
);
    import uart_pkg::*;

    localparam int unsigned CW = ptr_width(DEPTH) + 1;

    uart_byte_t    rx_data;
    logic          rx_done;
    logic          rd_en;
    logic          clr_ovf;
    uart_byte_t    rd_data;
    logic          rd_valid;
    logic          empty;
    logic          full;
    logic [CW-1:0] count;
    logic          overflow;
    logic          level_irq;

    modport slave (
        input  rx_data, rx_done, rd_en, clr_ovf,
        output rd_data, rd_valid, empty, full, count, overflow, level_irq
    );

    modport master (
        output rx_data, rx_done, rd_en, clr_ovf,
        input  rd_data, rd_valid, empty, full, count, overflow, level_irq
    );

endinterface

// File: rtl/uart_rx_fifo_mem.sv
// DEPTH x byte storage: synchronous write, synchronous registered read, no reset.
// Read returns the pre-write contents when both ports hit the same address.
module uart_rx_fifo_mem
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  uart_byte_t    wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output uart_byte_t    rdata
);

    uart_byte_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind the UART receiver: edge-detected capture of rx_done,
// circular buffer with explicit count, sticky overflow and threshold interrupt.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned THRESH = 8
) (
    input logic           clk,
    input logic           rst_n,
    uart_rx_fifo_if.slave bus
);

    localparam int unsigned PW = ptr_width(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic          rx_done_q;
    logic          armed_q;
    logic          wr;
    logic          push;
    logic          pop;
    logic          drop;
    logic          full_c;
    logic [PW-1:0] wptr_q;
    logic [PW-1:0] rptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          overflow_q;
    logic          overflow_d;
    logic          rd_valid_q;
    logic          loaded_q;
    uart_byte_t    mem_rdata;

    always_comb begin
        wr         = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        drop       = 1'b0;
        full_c     = 1'b0;
        count_d    = count_q;
        overflow_d = overflow_q;

        // armed_q masks the first post-reset cycle so a level held across reset is not an edge
        wr     = bus.rx_done & ~rx_done_q & armed_q;
        pop    = bus.rd_en & (count_q != '0);
        full_c = (count_q == CW'(DEPTH));
        push   = wr & (~full_c | pop);
        drop   = wr & full_c & ~pop;

        count_d = count_q + CW'(push) - CW'(pop);

        if (drop) begin
            overflow_d = 1'b1;
        end else if (bus.clr_ovf) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_done_q  <= 1'b0;
            armed_q    <= 1'b0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            rd_valid_q <= 1'b0;
            loaded_q   <= 1'b0;
        end else begin
            rx_done_q  <= bus.rx_done;
            armed_q    <= 1'b1;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            rd_valid_q <= pop;
            if (push) begin
                wptr_q <= wptr_q + PW'(1);
            end
            if (pop) begin
                rptr_q   <= rptr_q + PW'(1);
                loaded_q <= 1'b1;
            end
        end
    end

    uart_rx_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wptr_q),
        .wdata (bus.rx_data),
        .re    (pop),
        .raddr (rptr_q),
        .rdata (mem_rdata)
    );

    // Storage has no reset, so read data reads as zero until the first pop after reset.
    assign bus.rd_data   = loaded_q ? mem_rdata : '0;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.empty     = (count_q == '0);
    assign bus.full      = full_c;
    assign bus.count     = count_q;
    assign bus.overflow  = overflow_q;
    assign bus.level_irq = (count_q >= CW'(THRESH));

endmodule
